// File: rtl/alu_pkg.sv
// Shared definitions for the ALU32 scheduler: op codes, flag bit positions and FSM states.
package alu_pkg;
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SHIFT = 4'b0001;
    localparam logic [3:0] OP_LOGIC = 4'b0010;
    localparam logic [3:0] OP_MUL   = 4'b0011;

    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_EXEC,
        ST_RESP
    } state_t;

    function automatic logic is_legal(input logic [3:0] op);
        return op <= OP_MUL;
    endfunction
endpackage

// File: rtl/alu_sched_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            any
);
    // Scan from the farthest candidate down so the closest one to ptr wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NREQ]) begin
                idx = IW'((int'(ptr) + k) % NREQ);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU32 between NREQ requesters, one op in flight.
module alu_sched
    import alu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 1,
    parameter int MUL_LAT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [4*NREQ-1:0]        req_op,
    input  logic [4*NREQ-1:0]        req_op1,
    input  logic [32*NREQ-1:0]       req_a,
    input  logic [32*NREQ-1:0]       req_b,
    output logic [3:0]               alu_op,
    output logic [3:0]               alu_op1,
    output logic [31:0]              alu_in0,
    output logic [31:0]              alu_in1,
    input  logic [31:0]              alu_out,
    input  logic [31:0]              alu_out0,
    input  logic [3:0]               alu_flags,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [63:0]              rsp_data,
    output logic [3:0]               rsp_flags,
    output logic                     rsp_err,
    output logic                     busy
);
    localparam int IW = $clog2(NREQ);

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] sel;
    logic [IW-1:0] pick;
    logic          any;
    logic [7:0]    cnt;
    logic [3:0]    g_op;
    logic [3:0]    g_op1;
    logic [31:0]   g_a;
    logic [31:0]   g_b;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .idx (pick),
        .any (any)
    );

    assign g_op  = req_op[4*int'(sel) +: 4];
    assign g_op1 = req_op1[4*int'(sel) +: 4];
    assign g_a   = req_a[32*int'(sel) +: 32];
    assign g_b   = req_b[32*int'(sel) +: 32];
    assign busy  = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            sel       <= '0;
            cnt       <= '0;
            req_ready <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_flags <= '0;
            rsp_err   <= 1'b0;
            alu_op    <= '0;
            alu_op1   <= '0;
            alu_in0   <= '0;
            alu_in1   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any) begin
                        sel       <= pick;
                        req_ready <= NREQ'(1) << pick;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    req_ready <= '0;
                    if (!req_valid[sel]) begin
                        state <= ST_IDLE;
                    end else if (is_legal(g_op)) begin
                        alu_op  <= g_op;
                        alu_op1 <= g_op1;
                        alu_in0 <= g_a;
                        alu_in1 <= g_b;
                        cnt     <= (g_op == OP_MUL) ? 8'(MUL_LAT - 1) : 8'(ALU_LAT - 1);
                        state   <= ST_EXEC;
                    end else begin
                        // Illegal ops never reach the ALU, so alu_* keep the previous op.
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_flags <= '0;
                        rsp_id    <= sel;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_EXEC: begin
                    if (cnt == 8'd0) begin
                        rsp_data  <= (alu_op == OP_MUL) ? {alu_out, alu_out0} : {32'b0, alu_out};
                        rsp_flags <= alu_flags;
                        rsp_err   <= 1'b0;
                        rsp_id    <= sel;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ptr       <= (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched with a behavioural ALU32 stand-in.
module tb_alu_sched;
    import alu_pkg::*;

    localparam int NREQ    = 4;
    localparam int ALU_LAT = 1;
    localparam int MUL_LAT = 3;
    localparam int IW      = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [4*NREQ-1:0]   req_op;
    logic [4*NREQ-1:0]   req_op1;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [3:0]          alu_op;
    logic [3:0]          alu_op1;
    logic [31:0]         alu_in0;
    logic [31:0]         alu_in1;
    logic [31:0]         alu_out;
    logic [31:0]         alu_out0;
    logic [3:0]          alu_flags;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IW-1:0]       rsp_id;
    logic [63:0]         rsp_data;
    logic [3:0]          rsp_flags;
    logic                rsp_err;
    logic                busy;

    alu_sched #(.NREQ(NREQ), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_op1(req_op1), .req_a(req_a), .req_b(req_b),
        .alu_op(alu_op), .alu_op1(alu_op1), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_out(alu_out), .alu_out0(alu_out0), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [63:0] data;
        logic [3:0]  flags;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          grant_q[$];
    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          meas_lat = 0;
    int          handshakes = 0;
    int          issue_cnt[NREQ];
    int          hs_cnt[NREQ];
    int          waited[NREQ];
    logic [3:0]  t_op[NREQ];
    logic [3:0]  t_op1[NREQ];
    logic [31:0] t_a[NREQ];
    logic [31:0] t_b[NREQ];
    logic [63:0] e_data[NREQ];
    logic [3:0]  e_flags[NREQ];
    logic        e_err[NREQ];
    int          e_lat[NREQ];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // {N,Z,C,V, sum}
    function automatic logic [35:0] add_ref(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic        v;
        s = {1'b0, a} + {1'b0, b};
        v = (a[31] == b[31]) && (s[31] != a[31]);
        return {s[31], s[31:0] == 32'd0, s[32], v, s[31:0]};
    endfunction

    // Behavioural ALU32 stand-in
    logic [35:0] m_add;
    logic [63:0] m_prod;
    always_comb begin
        m_add     = add_ref(alu_in0, alu_in1);
        m_prod    = {32'b0, alu_in0} * {32'b0, alu_in1};
        alu_out   = 32'd0;
        alu_out0  = 32'd0;
        alu_flags = 4'd0;
        case (alu_op)
            OP_ADD: begin
                alu_out   = m_add[31:0];
                alu_flags = m_add[35:32];
            end
            OP_SHIFT: begin
                alu_out   = alu_in0 << alu_in1[4:0];
                alu_flags = {alu_out[31], alu_out == 32'd0, 2'b00};
            end
            OP_LOGIC: begin
                alu_out   = alu_in0 & alu_in1;
                alu_flags = {alu_out[31], alu_out == 32'd0, 2'b00};
            end
            OP_MUL: begin
                alu_out   = m_prod[63:32];
                alu_out0  = m_prod[31:0];
                alu_flags = {m_prod[63], m_prod == 64'd0, 2'b00};
            end
            default: ;
        endcase
    end

    always_comb begin
        req_valid = '0;
        req_op    = '0;
        req_op1   = '0;
        req_a     = '0;
        req_b     = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = (issue_cnt[i] != hs_cnt[i]);
            req_op[4*i +: 4]   = t_op[i];
            req_op1[4*i +: 4]  = t_op1[i];
            req_a[32*i +: 32]  = t_a[i];
            req_b[32*i +: 32]  = t_b[i];
        end
    end

    always @(posedge clk) cyc++;

    // Handshake watcher: push expectation, check grant order and waiting bound, retire request.
    int w_i;
    always @(negedge clk) begin
        if (!rst && (req_valid & req_ready) != '0) begin
            w_i = 0;
            for (int k = 0; k < NREQ; k++)
                if (req_valid[k] && req_ready[k]) w_i = k;
            sb.push_back('{w_i, e_data[w_i], e_flags[w_i], e_err[w_i], e_lat[w_i]});
            hs_cyc = cyc;
            handshakes++;
            if (grant_q.size() > 0) chk("grant_order", w_i, grant_q.pop_front());
            chk("fair_wait_bound", waited[w_i] <= NREQ - 1, 1);
            for (int j = 0; j < NREQ; j++)
                if (j != w_i && req_valid[j]) waited[j]++;
            waited[w_i] = 0;
            @(posedge clk);
            #1;
            hs_cnt[w_i]++;
        end
    end

    // Response monitor
    logic prev_v = 1'b0;
    exp_t m_e;
    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
        end else begin
            if (rsp_valid && !prev_v) meas_lat = cyc - hs_cyc;
            prev_v = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_rsp: got id %0d data %0h, required no response", rsp_id, rsp_data);
                end else begin
                    m_e = sb.pop_front();
                    chk("rsp_id", rsp_id, m_e.id);
                    chk("rsp_data", rsp_data, m_e.data);
                    chk("rsp_flags", rsp_flags, m_e.flags);
                    chk("rsp_err", rsp_err, m_e.err);
                    chk("rsp_latency", meas_lat, m_e.lat);
                end
            end
        end
    end

    task automatic issue(input int i, input logic [3:0] op, input logic [3:0] op1,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] d, input logic [3:0] f, input logic e, input int lat);
        t_op[i]    = op;
        t_op1[i]   = op1;
        t_a[i]     = a;
        t_b[i]     = b;
        e_data[i]  = d;
        e_flags[i] = f;
        e_err[i]   = e;
        e_lat[i]   = lat;
        issue_cnt[i]++;
    endtask

    task automatic drain(input string name, output int ready_hi);
        int n;
        ready_hi = 0;
        n = 0;
        do begin
            @(posedge clk);
            #2;
            if (req_ready != '0) ready_hi++;
            n++;
        end while (n < 400 && (req_valid != '0 || sb.size() != 0 || busy));
        if (n >= 400) chk({name, "_timeout"}, 0, 1);
    endtask

    task automatic check_reset(input string name);
        chk({name, "_req_ready"}, req_ready, 0);
        chk({name, "_rsp_valid"}, rsp_valid, 0);
        chk({name, "_rsp_id"}, rsp_id, 0);
        chk({name, "_rsp_data"}, rsp_data, 0);
        chk({name, "_rsp_flags"}, rsp_flags, 0);
        chk({name, "_rsp_err"}, rsp_err, 0);
        chk({name, "_alu_op"}, alu_op, 0);
        chk({name, "_alu_op1"}, alu_op1, 0);
        chk({name, "_alu_in0"}, alu_in0, 0);
        chk({name, "_alu_in1"}, alu_in1, 0);
        chk({name, "_busy"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    int          rh;
    int          base;
    int          issued_n;
    int          seen;
    int          h0;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [35:0] r;

    initial begin
        rst = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            t_op[i] = 4'd0; t_op1[i] = 4'd0; t_a[i] = 32'd0; t_b[i] = 32'd0;
            issue_cnt[i] = 0; hs_cnt[i] = 0; waited[i] = 0;
        end
        repeat (3) @(posedge clk);
        #2;
        check_reset("reset0");
        rst = 1'b0;

        // Single ADD on requester 0
        issue(0, OP_ADD, 4'd0, 32'd5, 32'd7, 64'd12, 4'b0000, 1'b0, 1 + ALU_LAT);
        drain("t1", rh);
        chk("t1_ready_pulse_cycles", rh, 1);

        // Fresh reset, then all four MUL: grants 0,1,2,3
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            grant_q.push_back(i);
            issue(i, OP_MUL, 4'd0, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE, 4'b0000, 1'b0, 1 + MUL_LAT);
        end
        drain("t2", rh);
        chk("t2_ready_pulse_cycles", rh, 4);

        // Wrap-around: after id 1 is served, requesters 1 and 3 -> 3 then 1
        grant_q.push_back(1);
        issue(1, OP_SHIFT, 4'd0, 32'd1, 32'd31, 64'h0000_0000_8000_0000, 4'b1000, 1'b0, 1 + ALU_LAT);
        drain("t3a", rh);
        grant_q.push_back(3);
        grant_q.push_back(1);
        issue(1, OP_LOGIC, 4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 64'h0000_0000_F000_F000, 4'b1000, 1'b0, 1 + ALU_LAT);
        issue(3, OP_ADD, 4'd0, 32'hFFFF_FFFF, 32'd1, 64'd0, 4'b0110, 1'b0, 1 + ALU_LAT);
        drain("t3b", rh);

        // 100 randomly arriving ADDs; fairness bound checked on every grant
        base = handshakes;
        issued_n = 0;
        for (int c = 0; c < 3000 && handshakes < base + 100; c++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NREQ; i++) begin
                if (issued_n < 100 && issue_cnt[i] == hs_cnt[i] && $urandom_range(0, 1) == 1) begin
                    ra = $urandom;
                    rb = $urandom;
                    r = add_ref(ra, rb);
                    issue(i, OP_ADD, 4'd0, ra, rb, {32'b0, r[31:0]}, r[35:32], 1'b0, 1 + ALU_LAT);
                    issued_n++;
                end
            end
        end
        drain("t3r", rh);
        chk("t3_random_ops_served", handshakes - base, 100);

        // Illegal op skips EXEC and leaves the ALU drive untouched
        issue(0, OP_LOGIC, 4'd1, 32'h1234_5678, 32'hFFFF_0000, 64'h0000_0000_1234_0000, 4'b0000, 1'b0, 1 + ALU_LAT);
        drain("t4a", rh);
        issue(2, 4'b0111, 4'hA, 32'hDEAD_BEEF, 32'hBEEF_DEAD, 64'd0, 4'b0000, 1'b1, 1);
        drain("t4b", rh);
        chk("t4_alu_op_held", alu_op, OP_LOGIC);
        chk("t4_alu_op1_held", alu_op1, 4'd1);
        chk("t4_alu_in0_held", alu_in0, 32'h1234_5678);
        chk("t4_alu_in1_held", alu_in1, 32'hFFFF_0000);

        // Back-pressure: response held for 10 cycles with another requester waiting
        rsp_ready = 1'b0;
        issue(0, OP_ADD, 4'd0, 32'h7FFF_FFFF, 32'd1, 64'h0000_0000_8000_0000, 4'b1001, 1'b0, 1 + ALU_LAT);
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(posedge clk);
            #2;
            if (rsp_valid) seen = 1;
        end
        chk("t5_rsp_valid_seen", seen, 1);
        issue(1, OP_ADD, 4'd0, 32'd1, 32'd1, 64'd2, 4'b0000, 1'b0, 1 + ALU_LAT);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #2;
            chk("t5_held_outputs", {rsp_valid, rsp_id, rsp_data, rsp_flags, req_ready, busy},
                {1'b1, 2'd0, 64'h0000_0000_8000_0000, 4'b1001, 4'b0000, 1'b1});
        end
        rsp_ready = 1'b1;
        drain("t5", rh);

        // Reset in the middle of a multiply
        issue(3, OP_MUL, 4'd0, 32'd3, 32'd5, 64'd15, 4'b0000, 1'b0, 1 + MUL_LAT);
        h0 = hs_cnt[3];
        for (int c = 0; c < 20 && hs_cnt[3] == h0; c++) begin
            @(posedge clk);
            #2;
        end
        chk("t6_handshake_seen", hs_cnt[3] != h0, 1);
        chk("t6_busy_in_exec", busy, 1);
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < NREQ; i++) issue_cnt[i] = hs_cnt[i];
        @(posedge clk);
        #2;
        check_reset("t6_reset");
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #2;
            if (rsp_valid) seen = 1;
        end
        chk("t6_no_rsp_after_abort", seen, 0);

        // Recovery after the abort
        grant_q.push_back(0);
        issue(0, OP_ADD, 4'd0, 32'd2, 32'd3, 64'd5, 4'b0000, 1'b0, 1 + ALU_LAT);
        drain("t6b", rh);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
